// File: rtl/inter_ctrl_arbiter.sv
// inter_ctrl_arbiter
//   Round-robin arbiter sharing one inter-board transmitter among N_REQ
//   requesters. Each requester owns a single pending slot (flag + payload).
//   A granted payload is strobed out for one cycle, then held until the
//   transmitter reports completion (inter_ready) or the wait times out.
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   interboard_rst  synchronous active-high reset, same effect as rst
//   req_en          per-requester one-cycle request strobe
//   req_payload     requester i payload at [i*PAYLOAD_W +: PAYLOAD_W]
//                   layout {move_dir, block_x[4:0], block_y[2:0],
//                           msg_type[3:0], card[5:0], sel_len[2:0]}
//   inter_ready     transmitter-finished pulse
//   out_en          one-cycle send strobe
//   out_payload     payload of the granted request (zero when idle)
//   req_done        one-cycle completion pulse per requester
//   req_err         one-cycle timeout-abort pulse per requester
//   overflow        sticky per-requester dropped-request flag
//   busy            arbiter is not idle
module inter_ctrl_arbiter #(
  parameter int N_REQ       = 4,
  parameter int PAYLOAD_W   = 22,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       interboard_rst,
  input  logic [N_REQ-1:0]           req_en,
  input  logic [N_REQ*PAYLOAD_W-1:0] req_payload,
  input  logic                       inter_ready,
  output logic                       out_en,
  output logic [PAYLOAD_W-1:0]       out_payload,
  output logic [N_REQ-1:0]           req_done,
  output logic [N_REQ-1:0]           req_err,
  output logic [N_REQ-1:0]           overflow,
  output logic                       busy
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_READY
  } state_t;

  state_t               state, state_nx;
  logic [N_REQ-1:0]     pend;
  logic [PAYLOAD_W-1:0] pend_buf [N_REQ];
  logic [N_REQ-1:0]     ovf_q;
  logic [N_REQ-1:0]     done_q;
  logic [N_REQ-1:0]     err_q;
  logic [GW-1:0]        gnt;
  logic [GW-1:0]        last_gnt;
  logic [GW-1:0]        rr_idx;
  logic                 rr_found;
  logic [CW-1:0]        cnt;
  logic                 rst_any;
  logic                 done_now;
  logic                 tout_now;

  assign rst_any  = rst | interboard_rst;
  assign done_now = (state == WAIT_READY) && inter_ready;
  assign tout_now = (state == WAIT_READY) && !inter_ready &&
                    (cnt == CW'(TIMEOUT_CYC));

  // Round-robin search starting just after the last served requester.
  always_comb begin
    int unsigned cand;
    rr_found = 1'b0;
    rr_idx   = last_gnt;
    cand     = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (last_gnt + k) % N_REQ;
      if (!rr_found && pend[GW'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = GW'(cand);
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:       if (|pend) state_nx = ISSUE;
      ISSUE:      state_nx = WAIT_READY;
      WAIT_READY: if (done_now || tout_now) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_any) begin
      state    <= IDLE;
      gnt      <= '0;
      last_gnt <= GW'(N_REQ - 1);
      cnt      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && rr_found)
        gnt <= rr_idx;
      if (state == ISSUE)
        cnt <= '0;
      else if (state == WAIT_READY && !done_now && !tout_now)
        cnt <= cnt + CW'(1);
      if (done_now || tout_now)
        last_gnt <= gnt;
    end
  end

  // Per-requester slot. A request arriving while its own transaction is
  // completing via inter_ready refills the slot instead of overflowing.
  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    logic is_gnt;
    logic keep;
    logic finish;

    assign is_gnt = (gnt == GW'(g));
    assign keep   = done_now && is_gnt;
    assign finish = (done_now || tout_now) && is_gnt;

    always_ff @(posedge clk) begin
      if (rst_any) begin
        pend[g]     <= 1'b0;
        pend_buf[g] <= '0;
        ovf_q[g]    <= 1'b0;
        done_q[g]   <= 1'b0;
        err_q[g]    <= 1'b0;
      end else begin
        done_q[g] <= done_now && is_gnt;
        err_q[g]  <= tout_now && is_gnt;
        if (finish)
          pend[g] <= 1'b0;
        if (req_en[g]) begin
          if (!pend[g] || keep) begin
            pend[g]     <= 1'b1;
            pend_buf[g] <= req_payload[g*PAYLOAD_W +: PAYLOAD_W];
          end else begin
            ovf_q[g] <= 1'b1;
          end
        end
      end
    end
  end

  assign out_en      = !rst_any && (state == ISSUE);
  assign busy        = !rst_any && (state != IDLE);
  assign out_payload = (rst_any || state == IDLE) ? '0 : pend_buf[gnt];
  assign req_done    = rst_any ? '0 : done_q;
  assign req_err     = rst_any ? '0 : err_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_inter_ctrl_arbiter.sv
module tb_inter_ctrl_arbiter;
  localparam int N  = 4;
  localparam int W  = 22;
  localparam int TO = 13;

  logic           clk = 1'b0;
  logic           rst;
  logic           interboard_rst;
  logic [N-1:0]   req_en;
  logic [N*W-1:0] req_payload;
  logic           inter_ready;
  logic           out_en;
  logic [W-1:0]   out_payload;
  logic [N-1:0]   req_done;
  logic [N-1:0]   req_err;
  logic [N-1:0]   overflow;
  logic           busy;

  always #5 clk = ~clk;

  inter_ctrl_arbiter #(.N_REQ(N), .PAYLOAD_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
    .req_en(req_en), .req_payload(req_payload), .inter_ready(inter_ready),
    .out_en(out_en), .out_payload(out_payload), .req_done(req_done),
    .req_err(req_err), .overflow(overflow), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: one pending slot per requester, and one
  // in-flight transaction described by its grant and its age in cycles
  // (age 0 is the send cycle, age >= 1 are waiting cycles).
  logic [N-1:0] m_pend;
  logic [W-1:0] m_buf [N];
  logic [N-1:0] m_ovf;
  logic [N-1:0] m_done;
  logic [N-1:0] m_err;
  int           m_last;
  bit           m_active;
  int           m_gnt;
  int           m_age;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_ovf = '0; m_done = '0; m_err = '0;
    for (int i = 0; i < N; i++) m_buf[i] = '0;
    m_last = N - 1; m_active = 0; m_gnt = 0; m_age = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] old_pend;
    logic [N-1:0] done_n;
    logic [N-1:0] err_n;
    bit ok, tout;
    if (rst || interboard_rst) begin
      model_reset();
      return;
    end
    old_pend = m_pend; done_n = '0; err_n = '0;
    ok   = m_active && m_age >= 1 && inter_ready;
    tout = m_active && m_age >= 1 && !inter_ready && (m_age - 1) == TO;
    for (int i = 0; i < N; i++) begin
      if (req_en[i]) begin
        if (!old_pend[i]) begin
          m_pend[i] = 1'b1; m_buf[i] = req_payload[i*W +: W];
        end else if (ok && i == m_gnt) begin
          m_buf[i] = req_payload[i*W +: W];
        end else begin
          m_ovf[i] = 1'b1;
        end
      end
    end
    if (ok) begin
      if (!req_en[m_gnt]) m_pend[m_gnt] = 1'b0;
      done_n[m_gnt] = 1'b1; m_last = m_gnt; m_active = 0;
    end else if (tout) begin
      m_pend[m_gnt] = 1'b0;
      err_n[m_gnt] = 1'b1; m_last = m_gnt; m_active = 0;
    end else if (m_active) begin
      m_age++;
    end else if (old_pend != '0) begin
      for (int k = 1; k <= N; k++) begin
        if (old_pend[(m_last + k) % N]) begin
          m_gnt = (m_last + k) % N;
          break;
        end
      end
      m_active = 1; m_age = 0;
    end
    m_done = done_n; m_err = err_n;
  endtask

  task automatic compare_all();
    bit r;
    r = rst || interboard_rst;
    check("out_en",      out_en,      (!r && m_active && m_age == 0) ? 1 : 0);
    check("out_payload", out_payload, (!r && m_active) ? m_buf[m_gnt] : '0);
    check("busy",        busy,        (!r && m_active) ? 1 : 0);
    check("req_done",    req_done,    r ? '0 : m_done);
    check("req_err",     req_err,     r ? '0 : m_err);
    check("overflow",    overflow,    m_ovf);
  endtask

  // Caller drives inputs at the falling edge; one clock cycle is applied
  // and the inputs return to idle at the next falling edge.
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
    req_en = '0; inter_ready = 1'b0; rst = 1'b0; interboard_rst = 1'b0;
  endtask

  task automatic send(input int i, input logic [W-1:0] val);
    req_en[i] = 1'b1;
    req_payload[i*W +: W] = val;
  endtask

  task automatic reset_dut();
    rst = 1'b1; req_en = '1;
    tick();
    rst = 1'b1;
    tick();
    check("rst_busy",     busy,        0);
    check("rst_out_en",   out_en,      0);
    check("rst_payload",  out_payload, 0);
    check("rst_overflow", overflow,    0);
  endtask

  int mode;

  initial begin
    rst = 1'b1; interboard_rst = 1'b0; inter_ready = 1'b0;
    req_en = '0; req_payload = '0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);

    // single request: send at t+2, done at t+4
    reset_dut();
    send(1, 22'h2A5F3); tick();
    check("single_t1_out_en", out_en, 0); tick();
    check("single_t2_out_en", out_en, 1);
    check("single_t2_payload", out_payload, 22'h2A5F3); tick();
    check("single_t3_busy", busy, 1);
    inter_ready = 1'b1; tick();
    check("single_t4_done", req_done, 4'b0010);
    check("single_t4_busy", busy, 0);

    // round robin after simultaneous requests
    reset_dut();
    for (int i = 0; i < N; i++) send(i, W'(22'h100 + i));
    tick(); tick();
    for (int g = 0; g < N; g++) begin
      check("rr_out_en", out_en, 1);
      check("rr_payload", out_payload, 22'h100 + g);
      tick();
      inter_ready = 1'b1; tick();
      check("rr_done", req_done, 4'b0001 << g);
      tick();
    end
    check("rr_idle_after", busy, 0);

    // overflow while busy on requester 0
    reset_dut();
    send(0, 22'h00AAA); tick(); tick();
    send(2, 22'h0BBBB); tick();
    send(2, 22'h0CCCC); tick();
    check("ovf_set", overflow, 4'b0100);
    send(2, 22'h0DDDD); tick();
    check("ovf_still", overflow, 4'b0100);
    inter_ready = 1'b1; tick();
    for (int k = 0; k < 8 && !out_en; k++) tick();
    check("ovf_grant_seen", out_en, 1);
    check("ovf_first_payload", out_payload, 22'h0BBBB);
    tick();
    inter_ready = 1'b1; tick();
    check("ovf_done2", req_done, 4'b0100);
    check("ovf_sticky", overflow, 4'b0100);

    // timeout on requester 3
    reset_dut();
    send(3, 22'h3F00F); tick(); tick(); tick();
    check("to_wait_busy", busy, 1);
    repeat (TO) tick();
    check("to_before_err", req_err, 0);
    check("to_before_busy", busy, 1);
    tick();
    check("to_err", req_err, 4'b1000);
    check("to_idle", busy, 0);
    check("to_no_done", req_done, 0);

    // request coincident with its own completion
    reset_dut();
    send(0, 22'h11111); tick(); tick(); tick();
    inter_ready = 1'b1; send(0, 22'h22222); tick();
    check("coin_done", req_done, 4'b0001);
    check("coin_no_ovf", overflow, 0);
    tick();
    check("coin_resend", out_en, 1);
    check("coin_payload", out_payload, 22'h22222);
    tick(); inter_ready = 1'b1; tick();

    // interboard reset mid-flight
    reset_dut();
    send(1, 22'h15555); tick(); tick(); tick();
    interboard_rst = 1'b1; inter_ready = 1'b1; tick();
    check("ibrst_idle", busy, 0);
    check("ibrst_no_done", req_done, 0);
    check("ibrst_no_err", req_err, 0);
    tick();
    check("ibrst_no_done2", req_done, 0);
    tick();
    check("ibrst_no_resend", out_en, 0);

    // randomized traffic against the model
    reset_dut();
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) mode = $urandom_range(0, 1);
      for (int i = 0; i < N; i++) begin
        req_en[i] = ($urandom_range(0, 5) == 0);
        req_payload[i*W +: W] = W'($urandom);
      end
      inter_ready    = (mode == 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 39) == 0);
      interboard_rst = ($urandom_range(0, 199) == 0);
      rst            = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inter_ctrl_arbiter.md
INTER_CTRL_ARBITER -- requirements
Module: inter_ctrl_arbiter

Interface
REQ-001 SHALL provide parameter N_REQ, default 4, number of requesters sharing the inter-board transmitter.
REQ-002 SHALL provide parameter PAYLOAD_W, default 22, per-request payload width.
REQ-003 SHALL provide parameter TIMEOUT_CYC, default 1023, maximum cycles to wait for inter_ready.
REQ-004 SHALL define the payload layout as {move_dir[21], block_x[20:16], block_y[15:13], msg_type[12:9], card[8:3], sel_len[2:0]}.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 interboard_rst  input  1  synchronous, active-high, same effect as rst.
REQ-008 req_en  input  N_REQ  per-requester one-cycle request strobe.
REQ-009 req_payload  input  N_REQ*PAYLOAD_W  requester i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
REQ-010 inter_ready  input  1  transmitter-finished pulse.
REQ-011 out_en  output  1  one-cycle send strobe to transmitter.
REQ-012 out_payload  output  PAYLOAD_W  payload of the granted request.
REQ-013 req_done  output  N_REQ  one-cycle completion pulse to requester i.
REQ-014 req_err  output  N_REQ  one-cycle timeout-abort pulse to requester i.
REQ-015 overflow  output  N_REQ  sticky flag: a request from i was dropped.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL hold one pending slot per requester: pend[i] bit plus buf[i] payload register.
REQ-018 req_en[i] with pend[i]=0 SHALL set pend[i] and load buf[i] at the next edge.
REQ-019 req_en[i] with pend[i]=1 SHALL be dropped and set overflow[i], except for the case in REQ-025.
REQ-020 SHALL implement states IDLE, ISSUE, WAIT_READY, registered; transitions occur only on clk edges.
REQ-021 IDLE with any pend set: latch gnt = first set index searching last_gnt+1, last_gnt+2, ... modulo N_REQ; go to ISSUE.
REQ-022 ISSUE: out_en=1 for exactly this cycle; out_payload=buf[gnt]; unconditionally go to WAIT_READY.
REQ-023 WAIT_READY: hold out_payload=buf[gnt]; run a timeout counter that is cleared on entry.
REQ-024 In WAIT_READY with inter_ready=1: clear pend[gnt], set last_gnt=gnt, pulse req_done[gnt] in the next cycle, go to IDLE.
REQ-025 If req_en[gnt] coincides with the completing inter_ready, SHALL load the new payload and keep pend[gnt]=1, without setting overflow.
REQ-026 In WAIT_READY with counter reaching TIMEOUT_CYC and no inter_ready: clear pend[gnt], set last_gnt=gnt, pulse req_err[gnt] in the next cycle, go to IDLE.
REQ-027 SHALL ignore inter_ready in IDLE and ISSUE.
REQ-028 out_payload SHALL be all-zero in IDLE.
REQ-029 Latency: req_en at cycle t into an idle arbiter SHALL give out_en at cycle t+2.
REQ-030 Minimum spacing between successive out_en pulses SHALL be 3 cycles, with inter_ready arriving in the first WAIT_READY cycle.
REQ-031 SHALL use a timeout counter wide enough for TIMEOUT_CYC, with no wrap before the compare.

Reset
REQ-032 rst or interboard_rst SHALL set state=IDLE, all pend=0, all buf=0, all overflow=0, last_gnt=N_REQ-1, and counter=0.
REQ-033 rst or interboard_rst SHALL drive out_en=0, out_payload=0, req_done=0, req_err=0, busy=0.
REQ-034 Reset asserted mid-transaction SHALL abort it without any req_done or req_err pulse.
REQ-035 req_en asserted during a reset cycle SHALL be discarded.

Verification
REQ-036 Single request: req_en[1] at t, payload 0x2A5F3; inter_ready at t+3 -> out_en at t+2 with 0x2A5F3, req_done[1] at t+4, busy low at t+4.
REQ-037 Round-robin: req_en=4'b1111 in one cycle after reset, inter_ready at each first WAIT_READY cycle -> grant order 0,1,2,3, four req_done pulses.
REQ-038 Overflow: req_en[2] twice while pend[2]=1 and the arbiter is busy on requester 0 -> overflow[2]=1; the first payload is sent; the sticky flag stays until reset.
REQ-039 Timeout: grant requester 3, never assert inter_ready -> req_err[3] pulses TIMEOUT_CYC+1 cycles after the WAIT_READY entry; the state returns to IDLE.
REQ-040 Coincident: req_en[0] in the same cycle as the inter_ready completing requester 0 -> no overflow, req_done[0], the new payload re-sent later.
REQ-041 Mid-flight interboard_rst while in WAIT_READY -> next cycle IDLE, pend=0, no req_done, no req_err.
